hazard_mw_ctrl: RTL and testbench

- Tracks destination and result-type control for the M and W pipeline stages of the 5-stage MIPS core.
- Inputs are the E-stage control outputs (read addresses, write address, result type) and the D-stage source and use information.
- Outputs are the D-stage stall request and the forwarding selects for the D, E and M operand muxes.
- Contains the E->M and M->W control pipeline registers; forwarding and stall logic is combinational from those registers plus the E/D inputs.

---
 rtl/hazard_mw_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_hazard_mw_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_mw_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_mw_ctrl
//
// Hazard and forwarding control for the 5-stage MIPS core. The block keeps
// the destination and result-type information of the M and W stages in its
// own control pipeline registers (E->M, M->W). From those registers and the
// current D/E stage information it computes the D-stage stall request and
// the forwarding selects for the D, E and M operand multiplexers.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           exception/eret flush of the M and W control registers
//   ra1D, ra2D      D-stage rs / rt register numbers
//   tuse1D, tuse2D  cycles until rs / rt is consumed (0..2, 3 = unused)
//   mdD             D instruction uses the mult/div unit or HI/LO
//   md_busy         mult/div unit busy or starting this cycle
//   ra1E, ra2E      E-stage rs / rt register numbers
//   waE, resE       E-stage destination register and result type
//   stall           freeze PC and D register, clear E register
//   fwd1D, fwd2D    D operand select: 0 RF, 1 W, 2 M, 3 E (PC+8)
//   fwd1E, fwd2E    E operand select: 0 E register, 1 W, 2 M
//   fwd2M           store-data select: 0 M register, 1 W
//   waW, resW       W-stage destination and result type
// ----------------------------------------------------------------------------
module hazard_mw_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic [4:0] ra1D,
    input  logic [4:0] ra2D,
    input  logic [1:0] tuse1D,
    input  logic [1:0] tuse2D,
    input  logic       mdD,
    input  logic       md_busy,
    input  logic [4:0] ra1E,
    input  logic [4:0] ra2E,
    input  logic [4:0] waE,
    input  logic [2:0] resE,
    output logic       stall,
    output logic [1:0] fwd1D,
    output logic [1:0] fwd2D,
    output logic [1:0] fwd1E,
    output logic [1:0] fwd2E,
    output logic       fwd2M,
    output logic [4:0] waW,
    output logic [2:0] resW
);

    // Result types carried down the pipeline.
    localparam logic [2:0] RES_NW  = 3'd0;
    localparam logic [2:0] RES_ALU = 3'd1;
    localparam logic [2:0] RES_DM  = 3'd2;
    localparam logic [2:0] RES_PC  = 3'd3;
    localparam logic [2:0] RES_MD  = 3'd4;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Cycles until an E-stage result is available for forwarding.
    function automatic logic [1:0] tnew_e(input logic [2:0] res);
        case (res)
            RES_ALU: tnew_e = 2'd1;
            RES_DM:  tnew_e = 2'd2;
            RES_MD:  tnew_e = 2'd1;
            default: tnew_e = 2'd0;   // PC+8 is ready in E; NW never matches
        endcase
    endfunction

    // Cycles until an M-stage result is available: only a load is still late.
    function automatic logic [1:0] tnew_m(input logic [2:0] res);
        tnew_m = (res == RES_DM) ? 2'd1 : 2'd0;
    endfunction

    // A stage really writes the register file only with a result type and
    // a non-zero destination; $0 writes are discarded and never match.
    function automatic logic is_writer(input logic [2:0] res, input logic [4:0] wa);
        is_writer = (res != RES_NW) && (wa != 5'd0);
    endfunction

    // Nearest-stage-first forward select. e_ok / m_ok / w_ok say whether
    // the stage can supply a value at all; 3 is only reachable for D.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] ra,
        input logic       e_ok,
        input logic [4:0] wa_e,
        input logic       m_ok,
        input logic [4:0] wa_m,
        input logic       w_ok,
        input logic [4:0] wa_w
    );
        if (e_ok && ra == wa_e)       fwd_sel = 2'd3;
        else if (m_ok && ra == wa_m)  fwd_sel = 2'd2;
        else if (w_ok && ra == wa_w)  fwd_sel = 2'd1;
        else                          fwd_sel = 2'd0;
    endfunction

    // ------------------------------------------------------------------
    // Control pipeline registers (E->M, M->W)
    // ------------------------------------------------------------------
    logic [4:0] ra2_m_q, ra2_m_d;
    logic [4:0] wa_m_q,  wa_m_d;
    logic [2:0] res_m_q, res_m_d;
    logic [4:0] wa_w_q,  wa_w_d;
    logic [2:0] res_w_q, res_w_d;

    // A flush squashes the instructions in M and W, so it clears the same
    // state that reset does.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        ra2_m_d = ra2E;
        wa_m_d  = waE;
        res_m_d = resE;
        wa_w_d  = wa_m_q;
        res_w_d = res_m_q;
        if (flush) begin
            ra2_m_d = 5'd0;
            wa_m_d  = 5'd0;
            res_m_d = RES_NW;
            wa_w_d  = 5'd0;
            res_w_d = RES_NW;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge value of the others, matching real hardware.
        // NOTE: reset is synchronous to match the rest of the core; only the
        // five small control registers exist, so all of them are reset.
        if (rst) begin
            ra2_m_q <= 5'd0;
            wa_m_q  <= 5'd0;
            res_m_q <= RES_NW;
            wa_w_q  <= 5'd0;
            res_w_q <= RES_NW;
        end else begin
            ra2_m_q <= ra2_m_d;
            wa_m_q  <= wa_m_d;
            res_m_q <= res_m_d;
            wa_w_q  <= wa_w_d;
            res_w_q <= res_w_d;
        end
    end

    // ------------------------------------------------------------------
    // Stall and forwarding logic
    // ------------------------------------------------------------------
    logic e_wr, m_wr, w_wr;
    logic e_pc_ok;      // E stage can forward (only PC+8 is ready in E)
    logic m_fwd_ok;     // M stage can forward (anything but a load)
    logic [1:0] tnew_e_v, tnew_m_v;
    logic hazard_rs, hazard_rt, stall_md;

    always_comb begin
        e_wr     = is_writer(resE, waE);
        m_wr     = is_writer(res_m_q, wa_m_q);
        w_wr     = is_writer(res_w_q, wa_w_q);
        e_pc_ok  = e_wr && (resE == RES_PC);
        m_fwd_ok = m_wr && (res_m_q == RES_ALU || res_m_q == RES_PC ||
                            res_m_q == RES_MD);
        tnew_e_v = tnew_e(resE);
        tnew_m_v = tnew_m(res_m_q);

        // Tnew never exceeds 2, so tuse = 3 (operand unused) cannot stall.
        hazard_rs = (e_wr && ra1D == waE    && tnew_e_v > tuse1D) ||
                    (m_wr && ra1D == wa_m_q && tnew_m_v > tuse1D);
        hazard_rt = (e_wr && ra2D == waE    && tnew_e_v > tuse2D) ||
                    (m_wr && ra2D == wa_m_q && tnew_m_v > tuse2D);
        stall_md  = mdD && md_busy;
        stall     = hazard_rs || hazard_rt || stall_md;

        fwd1D = fwd_sel(ra1D, e_pc_ok, waE, m_fwd_ok, wa_m_q, w_wr, wa_w_q);
        fwd2D = fwd_sel(ra2D, e_pc_ok, waE, m_fwd_ok, wa_m_q, w_wr, wa_w_q);
        fwd1E = fwd_sel(ra1E, 1'b0,    waE, m_fwd_ok, wa_m_q, w_wr, wa_w_q);
        fwd2E = fwd_sel(ra2E, 1'b0,    waE, m_fwd_ok, wa_m_q, w_wr, wa_w_q);
        fwd2M = w_wr && (ra2_m_q == wa_w_q);
    end

    assign waW  = wa_w_q;
    assign resW = res_w_q;

endmodule

// File: tb/tb_hazard_mw_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_mw_ctrl
//
// Directed testbench for hazard_mw_ctrl. Inputs change on the falling edge,
// outputs are sampled 1 time unit later, and the DUT registers capture on the
// rising edge. Expected values are hand-computed from the pipeline contents.
// ----------------------------------------------------------------------------
module tb_hazard_mw_ctrl;

    localparam logic [2:0] RES_NW  = 3'd0;
    localparam logic [2:0] RES_ALU = 3'd1;
    localparam logic [2:0] RES_DM  = 3'd2;
    localparam logic [2:0] RES_PC  = 3'd3;
    localparam logic [2:0] RES_MD  = 3'd4;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [4:0] ra1D, ra2D;
    logic [1:0] tuse1D, tuse2D;
    logic       mdD, md_busy;
    logic [4:0] ra1E, ra2E, waE;
    logic [2:0] resE;
    logic       stall;
    logic [1:0] fwd1D, fwd2D, fwd1E, fwd2E;
    logic       fwd2M;
    logic [4:0] waW;
    logic [2:0] resW;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_mw_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .ra1D    (ra1D),
        .ra2D    (ra2D),
        .tuse1D  (tuse1D),
        .tuse2D  (tuse2D),
        .mdD     (mdD),
        .md_busy (md_busy),
        .ra1E    (ra1E),
        .ra2E    (ra2E),
        .waE     (waE),
        .resE    (resE),
        .stall   (stall),
        .fwd1D   (fwd1D),
        .fwd2D   (fwd2D),
        .fwd1E   (fwd1E),
        .fwd2E   (fwd2E),
        .fwd2M   (fwd2M),
        .waW     (waW),
        .resW    (resW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Quiet inputs: no E writer, D reads nothing, no control strobes.
    task automatic idle();
        rst     = 1'b0;
        flush   = 1'b0;
        ra1D    = 5'd0;
        ra2D    = 5'd0;
        tuse1D  = 2'd3;
        tuse2D  = 2'd3;
        mdD     = 1'b0;
        md_busy = 1'b0;
        ra1E    = 5'd0;
        ra2E    = 5'd0;
        waE     = 5'd0;
        resE    = RES_NW;
    endtask

    // Move to the next cycle: registers capture on the rising edge in between.
    task automatic next_cycle();
        @(negedge clk);
        idle();
    endtask

    // Shared check of an empty M/W pipeline with reads that would otherwise hit.
    task automatic check_cleared(input string pfx);
        check({pfx, "_waW"},  waW,   0);
        check({pfx, "_resW"}, resW,  0);
        check({pfx, "_f1D"},  fwd1D, 0);
        check({pfx, "_f2D"},  fwd2D, 0);
        check({pfx, "_f1E"},  fwd1E, 0);
        check({pfx, "_f2E"},  fwd2E, 0);
        check({pfx, "_f2M"},  fwd2M, 0);
        check({pfx, "_stall"}, stall, 0);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        idle();
        #1;
        // Reset state
        check("rst_waW",  waW,   0);
        check("rst_resW", resW,  0);
        check("rst_stall", stall, 0);
        check("rst_f2M",  fwd2M, 0);

        // ---- Load-use: lw $2 in E, beq-like use of rs=2 (tuse 0) ----
        next_cycle();
        resE = RES_DM; waE = 5'd2; ra1D = 5'd2; tuse1D = 2'd0;
        #1;
        check("ld_E_stall", stall, 1);
        check("ld_E_f1D",   fwd1D, 0);
        next_cycle();
        ra1D = 5'd2; tuse1D = 2'd0;
        #1;
        check("ld_M_stall", stall, 1);
        check("ld_M_f1D",   fwd1D, 0);     // load in M never forwards from M
        next_cycle();
        ra1D = 5'd2; tuse1D = 2'd0;
        #1;
        check("ld_W_stall", stall, 0);
        check("ld_W_f1D",   fwd1D, 1);

        // Boundary: tuse = 1 stalls behind a load in E but not in M
        next_cycle();
        resE = RES_DM; waE = 5'd2; ra1D = 5'd2; tuse1D = 2'd1;
        #1;
        check("ld1_E_stall", stall, 1);
        next_cycle();
        ra1D = 5'd2; tuse1D = 2'd1;
        #1;
        check("ld1_M_stall", stall, 0);

        // ---- ALU result then branch use ----
        next_cycle();
        resE = RES_ALU; waE = 5'd3; ra2D = 5'd3; tuse2D = 2'd3;
        #1;
        check("tuse3_stall", stall, 0);    // unused operand never stalls
        next_cycle();
        resE = RES_ALU; waE = 5'd3; ra1D = 5'd3; tuse1D = 2'd0;
        #1;
        check("add_E_stall", stall, 1);
        next_cycle();
        ra1D = 5'd3; tuse1D = 2'd0; ra2D = 5'd3; tuse2D = 2'd0;
        #1;
        check("add_M_stall", stall, 0);
        check("add_M_f1D",   fwd1D, 2);    // M preferred over W (both write $3)
        check("add_M_f2D",   fwd2D, 2);

        // ---- jal link forwarded from E ----
        next_cycle();
        resE = RES_PC; waE = 5'd31; ra1D = 5'd31; tuse1D = 2'd0;
        ra2D = 5'd31; tuse2D = 2'd0;
        #1;
        check("jal_stall", stall, 0);
        check("jal_f1D",   fwd1D, 3);
        check("jal_f2D",   fwd2D, 3);

        // ---- Writes to $0 in E, M and W never match ----
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            resE = (i == 2) ? RES_DM : RES_ALU; waE = 5'd0;
            tuse1D = 2'd0; tuse2D = 2'd0;
        end
        #1;
        check("z_stall", stall, 0);
        check("z_f1D",   fwd1D, 0);
        check("z_f2D",   fwd2D, 0);
        check("z_f1E",   fwd1E, 0);
        check("z_f2E",   fwd2E, 0);
        check("z_f2M",   fwd2M, 0);
        check("z_waW",   waW,   0);
        check("z_resW",  resW,  1);

        // ---- Same reg in M (ALU) and W; store data from W ----
        next_cycle();
        resE = RES_ALU; waE = 5'd5;
        next_cycle();
        resE = RES_ALU; waE = 5'd5; ra2E = 5'd5;
        next_cycle();
        resE = RES_ALU; waE = 5'd7; ra1E = 5'd5; ra1D = 5'd5;
        #1;
        check("mw_f1E",   fwd1E, 2);
        check("mw_f2E",   fwd2E, 0);
        check("mw_f2M",   fwd2M, 1);
        check("mw_f1D",   fwd1D, 2);
        check("mw_waW",   waW,   5);
        check("mw_resW",  resW,  1);
        check("mw_stall", stall, 0);
        next_cycle();
        resE = RES_DM; waE = 5'd7;
        next_cycle();
        // Load to $7 in M, ALU to $7 in W: forwards must skip M.
        ra1E = 5'd7; ra2E = 5'd7; ra1D = 5'd7; tuse1D = 2'd1;
        #1;
        check("ldM_f1E",   fwd1E, 1);
        check("ldM_f2E",   fwd2E, 1);
        check("ldM_f1D",   fwd1D, 1);
        check("ldM_stall", stall, 0);

        // ---- mult/div busy ----
        next_cycle();
        mdD = 1'b1; md_busy = 1'b1;
        #1;
        check("md_busy_stall", stall, 1);
        md_busy = 1'b0;
        #1;
        check("md_idle_stall", stall, 0);
        mdD = 1'b0; md_busy = 1'b1;
        #1;
        check("md_nomd_stall", stall, 0);

        // ---- Flush with valid M/W writers ----
        next_cycle();
        resE = RES_ALU; waE = 5'd9;
        next_cycle();
        resE = RES_ALU; waE = 5'd10; ra2E = 5'd9;
        next_cycle();
        // M: $10 ALU (ra2M=9), W: $9 ALU; a load enters M while flushing.
        resE = RES_DM; waE = 5'd12; ra1D = 5'd12; tuse1D = 2'd0;
        #1;
        check("pre_fl_f2M", fwd2M, 1);
        flush = 1'b1;
        #1;
        check("fl_stall", stall, 1);       // stall still follows current inputs
        next_cycle();
        ra1D = 5'd10; tuse1D = 2'd0; ra2D = 5'd12; tuse2D = 2'd0;
        ra1E = 5'd10; ra2E = 5'd9;
        #1;
        check_cleared("fl");

        // ---- Reset mid-operation gives the same result ----
        next_cycle();
        resE = RES_ALU; waE = 5'd9;
        next_cycle();
        resE = RES_ALU; waE = 5'd10; ra2E = 5'd9;
        next_cycle();
        resE = RES_DM; waE = 5'd12;
        ra1E = 5'd10;
        #1;
        check("pre_rst_f1E", fwd1E, 2);
        rst = 1'b1;
        next_cycle();
        ra1D = 5'd10; tuse1D = 2'd0; ra2D = 5'd12; tuse2D = 2'd0;
        ra1E = 5'd10; ra2E = 5'd9;
        #1;
        check_cleared("rs");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
